// File: rtl/duck_sprite_renderer.sv
// Duck sprite pixel stage: hit test, sprite RAM addressing, palette lookup and wing-flap sequencer.
// Define DUCK_MIRROR_EN to flip the sprite horizontally when duck_dir = 1.
module duck_sprite_renderer #(
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 20,
  parameter int ANIM_DIV = 6
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  DuckX,
  input  logic [9:0]  DuckY,
  input  logic        duck_shot,
  input  logic        duck_dir,
  input  logic [2:0]  sprite_data,
  output logic [18:0] read_address,
  output logic [1:0]  frame_sel,
  output logic        is_duck,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue
);

  typedef enum logic [2:0] {ST_UP, ST_MID_A, ST_DOWN, ST_MID_B, ST_SHOT} anim_state_t;

  logic [10:0] dx, dy, col;
  logic        in_box;
  logic [18:0] addr_next;
  logic [18:0] read_address_reg;
  logic        in_box_d1_reg, in_box_d2_reg;
  logic        is_duck_reg, duck_next;
  logic [23:0] rgb_reg, pal_rgb;
  logic [2:0]  sync_reg;
  logic        vs_tick;
  anim_state_t state_reg, state_next;
  logic [5:0]  div_reg, div_next;

  // A negative difference sets bit 10, so the unsigned compare also rejects wrap-around
  assign dx = {1'b0, DrawX} - {1'b0, DuckX};
  assign dy = {1'b0, DrawY} - {1'b0, DuckY};
  assign in_box = ~dx[10] & ~dy[10] & (dx < 11'(SPRITE_W)) & (dy < 11'(SPRITE_H));

`ifdef DUCK_MIRROR_EN
  assign col = duck_dir ? (11'(SPRITE_W - 1) - dx) : dx;
`else
  logic unused_dir;
  assign unused_dir = duck_dir;
  assign col = dx;
`endif

  assign addr_next = in_box ? (19'(dy) * 19'(SPRITE_W) + 19'(col)) : '0;
  assign duck_next = in_box_d2_reg & (sprite_data != 3'd0);

  always_comb begin
    pal_rgb = 24'h000000;
    case (sprite_data)
      3'd1: pal_rgb = 24'h000000;
      3'd2: pal_rgb = 24'hFFFFFF;
      3'd3: pal_rgb = 24'h3C7A1E;
      3'd4: pal_rgb = 24'h8B4513;
      3'd5: pal_rgb = 24'hE8C010;
      3'd6: pal_rgb = 24'hD03020;
      3'd7: pal_rgb = 24'hA0A0A0;
      default: pal_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address_reg <= '0;
      in_box_d1_reg    <= 1'b0;
      in_box_d2_reg    <= 1'b0;
      is_duck_reg      <= 1'b0;
      rgb_reg          <= '0;
    end else begin
      read_address_reg <= addr_next;
      in_box_d1_reg    <= in_box;
      in_box_d2_reg    <= in_box_d1_reg;
      is_duck_reg      <= duck_next;
      rgb_reg          <= duck_next ? pal_rgb : 24'h000000;
    end
  end

  assign read_address = read_address_reg;
  assign is_duck      = is_duck_reg;
  assign Red          = rgb_reg[23:16];
  assign Green        = rgb_reg[15:8];
  assign Blue         = rgb_reg[7:0];

  // sync_reg[1] is the synchronised level, sync_reg[2] its previous value
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], frame_clk};
    end
  end
  assign vs_tick = sync_reg[1] & ~sync_reg[2];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_UP;
      div_reg   <= '0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
    end
  end

  // A shot change takes priority over, and swallows, a coincident vs_tick
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    frame_sel  = 2'd0;
    if (duck_shot) begin
      state_next = ST_SHOT;
      div_next   = '0;
    end else if (state_reg == ST_SHOT) begin
      state_next = ST_UP;
      div_next   = '0;
    end else if (vs_tick) begin
      if (div_reg == 6'(ANIM_DIV - 1)) begin
        div_next = '0;
        case (state_reg)
          ST_UP:    state_next = ST_MID_A;
          ST_MID_A: state_next = ST_DOWN;
          ST_DOWN:  state_next = ST_MID_B;
          default:  state_next = ST_UP;
        endcase
      end else begin
        div_next = div_reg + 6'd1;
      end
    end
    case (state_reg)
      ST_MID_A: frame_sel = 2'd1;
      ST_DOWN:  frame_sel = 2'd2;
      ST_MID_B: frame_sel = 2'd1;
      ST_SHOT:  frame_sel = 2'd3;
      default:  frame_sel = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_duck_sprite_renderer.sv
// Randomised self-checking bench for duck_sprite_renderer with a behavioural sprite RAM.
module tb_duck_sprite_renderer;
  localparam int TB_ANIM_DIV = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, DuckX = '0, DuckY = '0;
  logic        duck_shot = 1'b0, duck_dir = 1'b0;
  logic [2:0]  sprite_data = '0;
  logic [18:0] read_address;
  logic [1:0]  frame_sel;
  logic        is_duck;
  logic [7:0]  Red, Green, Blue;

  int checks = 0;
  int failures = 0;

  logic [2:0]  mem [0:3][0:399];
  logic [23:0] pal [0:7];

  duck_sprite_renderer #(.SPRITE_W(20), .SPRITE_H(20), .ANIM_DIV(TB_ANIM_DIV)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .DuckX(DuckX), .DuckY(DuckY),
    .duck_shot(duck_shot), .duck_dir(duck_dir), .sprite_data(sprite_data),
    .read_address(read_address), .frame_sel(frame_sel), .is_duck(is_duck),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  always #5 Clk = ~Clk;

  // Sprite frame RAMs: one-cycle registered read, bank chosen by frame_sel
  always @(posedge Clk) sprite_data <= mem[frame_sel][int'(read_address) % 400];

  function automatic bit model_in(int px, int py, int kx, int ky);
    return (px - kx >= 0) && (px - kx < 20) && (py - ky >= 0) && (py - ky < 20);
  endfunction

  function automatic int model_addr(int px, int py, int kx, int ky, bit dir);
    int col;
    if (!model_in(px, py, kx, ky)) return 0;
    col = px - kx;
`ifdef DUCK_MIRROR_EN
    if (dir) col = 19 - col;
`endif
    return (py - ky) * 20 + col;
  endfunction

  function automatic logic [23:0] model_rgb(int fs, int px, int py, int kx, int ky, bit dir);
    int idx;
    if (!model_in(px, py, kx, ky)) return 24'h0;
    idx = int'(mem[fs][model_addr(px, py, kx, ky, dir)]);
    return pal[idx];
  endfunction

  function automatic bit model_duck(int fs, int px, int py, int kx, int ky, bit dir);
    if (!model_in(px, py, kx, ky)) return 1'b0;
    return mem[fs][model_addr(px, py, kx, ky, dir)] != 3'd0;
  endfunction

  task automatic hold_pixel(input int px, input int py, output logic [18:0] a,
                            output logic d, output logic [23:0] c);
    DrawX = 10'(px); DrawY = 10'(py);
    @(posedge Clk); #1;
    a = read_address;
    repeat (2) @(posedge Clk);
    #1;
    d = is_duck; c = {Red, Green, Blue};
  endtask

  task automatic pulse_frame();
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    DuckX = 10'd100; DuckY = 10'd50; DrawX = 10'd105; DrawY = 10'd53;
    mem[0][65] = 3'd3;
    repeat (4) @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    checks++;
    if (read_address !== 19'd0 || frame_sel !== 2'd0 || is_duck !== 1'b0 || {Red, Green, Blue} !== 24'h0) begin
      failures++;
      $display("FAIL reset_async got addr=%0d fsel=%0d duck=%0b rgb=%06h exp all 0",
               read_address, frame_sel, is_duck, {Red, Green, Blue});
    end
    @(posedge Clk); #1 Reset_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge Clk); #1;
      checks++;
      if (is_duck !== (c == 3)) begin
        failures++;
        $display("FAIL reset_release_latency cycle=%0d got duck=%0b exp=%0b", c, is_duck, c == 3);
      end
    end
    checks++;
    if ({Red, Green, Blue} !== 24'h3C7A1E) begin
      failures++;
      $display("FAIL reset_first_rgb got=%06h exp=3c7a1e", {Red, Green, Blue});
    end
  endtask

  task automatic test_hit();
    int tbl [0:7][0:3] = '{'{100, 50, 105, 53}, '{100, 50, 99, 53}, '{100, 50, 120, 53},
                          '{100, 50, 105, 70}, '{100, 50, 106, 53}, '{630, 50, 2, 53},
                          '{630, 50, 639, 53}, '{100, 50, 119, 69}};
    logic [18:0] a; logic d; logic [23:0] c;
    mem[0][65] = 3'd3;
    mem[0][66] = 3'd0;
    for (int i = 0; i < 8; i++) begin
      DuckX = 10'(tbl[i][0]); DuckY = 10'(tbl[i][1]);
      hold_pixel(tbl[i][2], tbl[i][3], a, d, c);
      checks++;
      if (a !== 19'(model_addr(tbl[i][2], tbl[i][3], tbl[i][0], tbl[i][1], 1'b0))) begin
        failures++;
        $display("FAIL hit_addr case=%0d got=%0d exp=%0d", i, a,
                 model_addr(tbl[i][2], tbl[i][3], tbl[i][0], tbl[i][1], 1'b0));
      end
      checks++;
      if (d !== model_duck(0, tbl[i][2], tbl[i][3], tbl[i][0], tbl[i][1], 1'b0) ||
          c !== model_rgb(0, tbl[i][2], tbl[i][3], tbl[i][0], tbl[i][1], 1'b0)) begin
        failures++;
        $display("FAIL hit_pixel case=%0d got duck=%0b rgb=%06h exp duck=%0b rgb=%06h", i, d, c,
                 model_duck(0, tbl[i][2], tbl[i][3], tbl[i][0], tbl[i][1], 1'b0),
                 model_rgb(0, tbl[i][2], tbl[i][3], tbl[i][0], tbl[i][1], 1'b0));
      end
    end
    DuckX = 10'd100; DuckY = 10'd50;
    hold_pixel(105, 53, a, d, c);
    checks++;
    if (a !== 19'd65 || d !== 1'b1 || c !== 24'h3C7A1E) begin
      failures++;
      $display("FAIL hit_known got addr=%0d duck=%0b rgb=%06h exp addr=65 duck=1 rgb=3c7a1e", a, d, c);
    end
    DuckX = 10'd630;
    hold_pixel(639, 53, a, d, c);
    checks++;
    if (a !== 19'd69) begin
      failures++;
      $display("FAIL edge_clip_addr got=%0d exp=69", a);
    end
  endtask

  task automatic test_mirror();
    logic [18:0] a; logic d; logic [23:0] c;
    DuckX = 10'd100; DuckY = 10'd50; duck_dir = 1'b1;
    hold_pixel(100, 50, a, d, c);
    checks++;
    if (a !== 19'(model_addr(100, 50, 100, 50, 1'b1))) begin
      failures++;
      $display("FAIL mirror_addr got=%0d exp=%0d", a, model_addr(100, 50, 100, 50, 1'b1));
    end
    hold_pixel(107, 62, a, d, c);
    checks++;
    if (a !== 19'(model_addr(107, 62, 100, 50, 1'b1)) || c !== model_rgb(0, 107, 62, 100, 50, 1'b1)) begin
      failures++;
      $display("FAIL mirror_pixel got addr=%0d rgb=%06h exp addr=%0d rgb=%06h", a, c,
               model_addr(107, 62, 100, 50, 1'b1), model_rgb(0, 107, 62, 100, 50, 1'b1));
    end
    duck_dir = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [18:0] e_addr [0:299];
    logic        e_duck [0:299];
    logic [23:0] e_rgb  [0:299];
    int kx = 0, ky = 0, px, py;
    bit dir;
    for (int n = 0; n < 300; n++) begin
      if (n % 40 == 0) begin
        kx = int'($urandom_range(0, 639)); ky = int'($urandom_range(0, 479));
        DuckX = 10'(kx); DuckY = 10'(ky);
      end
      px = kx + int'($urandom_range(0, 26)) - 3;
      py = ky + int'($urandom_range(0, 26)) - 3;
      if (px < 0) px = 0;
      if (px > 639) px = 639;
      if (py < 0) py = 0;
      if (py > 479) py = 479;
      dir = 1'($urandom_range(0, 1));
      DrawX = 10'(px); DrawY = 10'(py); duck_dir = dir;
      e_addr[n] = 19'(model_addr(px, py, kx, ky, dir));
      e_duck[n] = model_duck(0, px, py, kx, ky, dir);
      e_rgb[n]  = model_rgb(0, px, py, kx, ky, dir);
      @(posedge Clk); #1;
      checks++;
      if (read_address !== e_addr[n]) begin
        failures++;
        $display("FAIL stream_addr n=%0d got=%0d exp=%0d", n, read_address, e_addr[n]);
      end
      if (n >= 2) begin
        checks++;
        if (is_duck !== e_duck[n-2] || {Red, Green, Blue} !== e_rgb[n-2]) begin
          failures++;
          $display("FAIL stream_pixel n=%0d got duck=%0b rgb=%06h exp duck=%0b rgb=%06h",
                   n - 2, is_duck, {Red, Green, Blue}, e_duck[n-2], e_rgb[n-2]);
        end
      end
    end
    duck_dir = 1'b0;
  endtask

  task automatic test_anim();
    int seq [0:3] = '{0, 1, 2, 1};
    for (int p = 1; p <= 8; p++) begin
      pulse_frame();
      checks++;
      if (frame_sel !== 2'(seq[(p / TB_ANIM_DIV) % 4])) begin
        failures++;
        $display("FAIL anim_step pulse=%0d got=%0d exp=%0d", p, frame_sel, seq[(p / TB_ANIM_DIV) % 4]);
      end
    end
  endtask

  task automatic test_shot();
    repeat (3) pulse_frame();
    checks++;
    if (frame_sel !== 2'd1) begin
      failures++;
      $display("FAIL shot_pre got=%0d exp=1", frame_sel);
    end
    duck_shot = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (frame_sel !== 2'd3) begin
      failures++;
      $display("FAIL shot_enter got=%0d exp=3", frame_sel);
    end
    pulse_frame();
    checks++;
    if (frame_sel !== 2'd3) begin
      failures++;
      $display("FAIL shot_hold got=%0d exp=3", frame_sel);
    end
    duck_shot = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (frame_sel !== 2'd0) begin
      failures++;
      $display("FAIL shot_exit got=%0d exp=0", frame_sel);
    end
    for (int p = 1; p <= TB_ANIM_DIV; p++) begin
      pulse_frame();
      checks++;
      if (frame_sel !== ((p == TB_ANIM_DIV) ? 2'd1 : 2'd0)) begin
        failures++;
        $display("FAIL shot_div_restart pulse=%0d got=%0d exp=%0d", p, frame_sel, (p == TB_ANIM_DIV) ? 1 : 0);
      end
    end
  endtask

  initial begin
    pal[0] = 24'h000000; pal[1] = 24'h000000; pal[2] = 24'hFFFFFF; pal[3] = 24'h3C7A1E;
    pal[4] = 24'h8B4513; pal[5] = 24'hE8C010; pal[6] = 24'hD03020; pal[7] = 24'hA0A0A0;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 400; i++)
        mem[f][i] = 3'($urandom_range(0, 7));
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    test_reset();
    test_hit();
    test_mirror();
    test_back_to_back();
    test_anim();
    test_shot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/duck_sprite_renderer.md
Name: duck_sprite_renderer

Overview:
- Pixel-pipeline stage directly downstream of the duck sprite frame RAMs: 20x20 sprites, 400 entries, 3-bit palette index, 1-cycle registered read.
- Takes VGA draw coordinates and duck position, drives read_address into the sprite RAMs, and selects the animation frame.
- Converts the returned palette index to 24-bit RGB plus a hit flag for the colour mapper.
- Also sequences the wing-flap animation from the vertical-sync frame clock.

Parameters:
- SPRITE_W, 20, sprite width in pixels
- SPRITE_H, 20, sprite height in pixels
- ANIM_DIV, 6, frame_clk rising edges per animation step (1..63)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  vsync-rate frame clock, asynchronous to sprite logic; synchronised internally
- DrawX  in  10  current pixel column, 0..639
- DrawY  in  10  current pixel row, 0..479
- DuckX  in  10  sprite top-left column
- DuckY  in  10  sprite top-left row
- duck_shot  in  1  1 = shot pose, 0 = flying
- duck_dir  in  1  1 = facing left (used only with the optional feature)
- sprite_data  in  3  palette index from the frame RAM selected by frame_sel
- read_address  out  19  sprite RAM read address
- frame_sel  out  2  RAM select: 0 = up, 1 = middle, 2 = down, 3 = shot
- is_duck  out  1  pixel is an opaque duck pixel
- Red  out  8  pixel colour
- Green  out  8  pixel colour
- Blue  out  8  pixel colour

Behaviour:
- Reset (async assert, sync release):
  - read_address = 0, frame_sel = 0, is_duck = 0, RGB = 0.
  - Animation state = UP, divider = 0, synchroniser and pipeline flops cleared.
- Hit test, cycle 0:
  - dx = DrawX − DuckX and dy = DrawY − DuckY, computed 11-bit signed.
  - in_box when 0 ≤ dx < SPRITE_W and 0 ≤ dy < SPRITE_H.
  - No wrap: a sprite near the 639/479 edge is clipped.
- Address, registered at the end of cycle 0:
  - read_address = dy*SPRITE_W + dx, zero-extended to 19 bits; range 0..399.
  - When not in_box, read_address = 0.
  - in_box is delayed to match the RAM.
- Cycle 1: the RAM returns sprite_data.
- Output, registered at the end of cycle 2:
  - is_duck = in_box_d2 & (sprite_data ≠ 0).
  - RGB comes from the palette.
  - Total latency DrawX/DrawY → RGB/is_duck = 3 Clk.
- Palette; index 0 is transparent (is_duck = 0, RGB = 0):
  - 1 = 000000, 2 = FFFFFF, 3 = 3C7A1E, 4 = 8B4513
  - 5 = E8C010, 6 = D03020, 7 = A0A0A0
- frame_clk handling:
  - Two-flop synchroniser, then rising-edge detect, giving a one-Clk pulse vs_tick.
- Animation FSM (ping-pong UP → MID_A → DOWN → MID_B → UP):
  - States drive frame_sel 0, 1, 2, 1.
  - Divider increments on vs_tick.
  - When divider reaches ANIM_DIV−1 together with a vs_tick, the divider wraps to 0 and the FSM advances one state.
- SHOT state:
  - Entered on the Clk after duck_shot = 1, from any state; frame_sel = 3; divider held at 0.
  - On duck_shot 1→0, the FSM returns to UP with divider 0.
  - If duck_shot changes in the same cycle as a vs_tick, the state change wins and the tick is discarded.
- frame_sel and the address registers update on the same Clk edge.
  - A frame change mid-scanline therefore affects only pixels entering the pipeline afterwards.

Optional Feature:
- Macro DUCK_MIRROR_EN.
- Defined: when duck_dir = 1, read_address = dy*SPRITE_W + (SPRITE_W−1−dx), a horizontal flip. Latency unchanged.
- Undefined: duck_dir is ignored and the sprite is always drawn unmirrored.

Test Plan:
- Reset_n low mid-frame, with DuckX = 100 and DrawX = 105 → all outputs 0 immediately (asynchronous); first hit pixel appears 3 Clk after release.
- DuckX = 100, DuckY = 50, DrawX = 105, DrawY = 53 → read_address = 65 one Clk later; with sprite_data = 3, is_duck = 1 and RGB = 3C7A1E at cycle 3.
- DrawX = 99 or 120, or DrawY = 70 (same duck) → read_address = 0 and is_duck = 0; sprite_data = 0 inside the box → is_duck = 0 and RGB = 0.
- DuckX = 630, DrawX = 2 (wrap attempt) → is_duck = 0; DrawX = 639 → read_address = dy*20 + 9.
- ANIM_DIV = 2, 8 frame_clk pulses → frame_sel steps 0, 1, 2, 1, 0 at every 2nd pulse.
- duck_shot = 1 mid-animation → frame_sel = 3 the next Clk; clearing it → frame_sel = 0, and the divider restarts from 0.
- With DUCK_MIRROR_EN, duck_dir = 1, dx = 0, dy = 0 → read_address = 19.
